// File: rtl/score_pkg.sv
// Shared types, default widths and the saturating adder for the score_keeper block.
package score_pkg;

  localparam int P_ROUND  = 4;
  localparam int P_LEVEL  = 2;
  localparam int P_MAP    = 2;
  localparam int P_POINTS = 8;
  localparam int N_MAPS   = 2 ** P_MAP;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  function automatic logic [P_POINTS-1:0] sat_add(input logic [P_POINTS-1:0] a,
                                                  input logic [P_POINTS-1:0] b);
    logic [P_POINTS:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[P_POINTS] ? '1 : sum[P_POINTS-1:0];
  endfunction

endpackage

// File: rtl/score_hiscore_table.sv
// Per-map high-score register file: one synchronous write port, one combinational read port.
module score_hiscore_table
  import score_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [P_MAP-1:0]    wr_idx,
  input  logic [P_POINTS-1:0] wr_data,
  input  logic [P_MAP-1:0]    rd_idx,
  output logic [P_POINTS-1:0] rd_data
);

  logic [P_POINTS-1:0] mem [N_MAPS];

  // NOTE: the table is tiny and must read back 0 after reset, so it is built
  // from resettable flops rather than an uninitialised RAM macro.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_MAPS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/score_keeper.sv
// Round/score accumulator for the memory-sequence game with a per-map high-score commit.
// Optional feature macro: SCORE_KEEPER_HISCORE_EN (high-score table and record detection).
module score_keeper
  import score_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic                game_start,
  input  logic                round_ok,
  input  logic                game_end,
  input  logic [P_LEVEL-1:0]  setup_level,
  input  logic [P_MAP-1:0]    setup_map,
  output logic [P_ROUND-1:0]  round,
  output logic [P_POINTS-1:0] points,
  output logic [P_POINTS-1:0] best_points,
  output logic                new_record,
  output logic                done,
  output logic                busy
);

  state_t              state, state_nxt;
  logic [P_LEVEL-1:0]  level_q;
  logic [P_MAP-1:0]    map_q;
  logic [P_ROUND-1:0]  round_nxt;
  logic [P_POINTS-1:0] points_nxt;
  logic [P_POINTS-1:0] incr;
  logic                latch_setup;
  logic                beats_best;

  assign incr = P_POINTS'(level_q) + P_POINTS'(1);

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave a value held (no latches).
  always_comb begin
    state_nxt   = state;
    round_nxt   = round;
    points_nxt  = points;
    latch_setup = 1'b0;
    unique case (state)
      IDLE: begin
        if (game_start) begin
          latch_setup = 1'b1;
          round_nxt   = '0;
          points_nxt  = '0;
          state_nxt   = PLAY;
        end
      end
      PLAY: begin
        if (game_start) begin
          latch_setup = 1'b1;
          round_nxt   = '0;
          points_nxt  = '0;
        end else begin
          // The round is counted before game_end so a same-cycle pair commits it.
          if (round_ok) begin
            round_nxt  = (round == '1) ? round : round + P_ROUND'(1);
            points_nxt = sat_add(points, incr);
          end
          if (game_end) state_nxt = COMMIT;
        end
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      round      <= '0;
      points     <= '0;
      level_q    <= '0;
      map_q      <= '0;
      new_record <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      round      <= round_nxt;
      points     <= points_nxt;
      new_record <= (state_nxt == COMMIT) && beats_best;
      done       <= (state_nxt == COMMIT);
      busy       <= (state_nxt != IDLE);
      if (latch_setup) begin
        level_q <= setup_level;
        map_q   <= setup_map;
      end
    end
  end

`ifdef SCORE_KEEPER_HISCORE_EN
  logic table_we;

  // new_record is high exactly during COMMIT when the final score beats the entry.
  assign table_we   = (state == COMMIT) && new_record;
  assign beats_best = points_nxt > best_points;

  score_hiscore_table u_table (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (table_we),
    .wr_idx  (map_q),
    .wr_data (points),
    .rd_idx  (map_q),
    .rd_data (best_points)
  );
`else
  logic unused_map;

  assign unused_map  = ^map_q;
  assign beats_best  = 1'b0;
  assign best_points = '0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper; expectations follow SCORE_KEEPER_HISCORE_EN.
module tb_score_keeper;
  import score_pkg::*;

`ifdef SCORE_KEEPER_HISCORE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic                game_start = 1'b0;
  logic                round_ok = 1'b0;
  logic                game_end = 1'b0;
  logic [P_LEVEL-1:0]  setup_level = '0;
  logic [P_MAP-1:0]    setup_map = '0;
  logic [P_ROUND-1:0]  round;
  logic [P_POINTS-1:0] points;
  logic [P_POINTS-1:0] best_points;
  logic                new_record;
  logic                done;
  logic                busy;

  score_keeper dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .game_start  (game_start),
    .round_ok    (round_ok),
    .game_end    (game_end),
    .setup_level (setup_level),
    .setup_map   (setup_map),
    .round       (round),
    .points      (points),
    .best_points (best_points),
    .new_record  (new_record),
    .done        (done),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int round;
    int points;
    int best;
    bit nr;
    bit done;
    bit busy;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: 0 idle, 1 play, 2 commit.
  int m_state, m_round, m_points, m_level, m_map;
  int m_tbl[4];
  bit m_pend;

  task automatic model_reset();
    m_state = 0; m_round = 0; m_points = 0; m_level = 0; m_map = 0; m_pend = 0;
    for (int i = 0; i < 4; i++) m_tbl[i] = 0;
  endtask

  task automatic model_edge(input bit gs, input bit ro, input bit ge);
    exp_t e;
    e.nr = 0; e.done = 0;
    if (m_state == 2) begin
      if (m_pend) m_tbl[m_map] = m_points;
      m_pend  = 0;
      m_state = 0;
    end else if (gs) begin
      m_level = int'(setup_level); m_map = int'(setup_map);
      m_round = 0; m_points = 0; m_state = 1;
    end else if (m_state == 1) begin
      if (ro) begin
        m_round  = (m_round + 1 > 15) ? 15 : m_round + 1;
        m_points = (m_points + m_level + 1 > 255) ? 255 : m_points + m_level + 1;
      end
      if (ge) begin
        m_pend  = HS && (m_points > m_tbl[m_map]);
        e.nr    = m_pend;
        e.done  = 1;
        m_state = 2;
      end
    end
    e.round  = m_round;
    e.points = m_points;
    e.busy   = (m_state != 0);
    e.best   = HS ? m_tbl[m_map] : 0;
    sb_q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL sb_empty: no expected entry queued");
      return;
    end
    e = sb_q.pop_front();
    n_vec++;
    if (round !== 4'(e.round) || points !== 8'(e.points) || best_points !== 8'(e.best) ||
        new_record !== e.nr || done !== e.done || busy !== e.busy) begin
      n_err++;
      $display("FAIL sb_outputs @%0t: got r=%0d p=%0d b=%0d nr=%b d=%b busy=%b want r=%0d p=%0d b=%0d nr=%b d=%b busy=%b",
               $time, round, points, best_points, new_record, done, busy,
               e.round, e.points, e.best, e.nr, e.done, e.busy);
    end
  endtask

  // Drive one cycle of pulses from a falling edge, check at the next falling edge.
  task automatic step(input bit gs, input bit ro, input bit ge);
    game_start = gs; round_ok = ro; game_end = ge;
    model_edge(gs, ro, ge);
    @(negedge clock);
    game_start = 0; round_ok = 0; game_end = 0;
    sb_check();
  endtask

  task automatic run_game(input int lvl, input int map, input int rounds);
    setup_level = 2'(lvl); setup_map = 2'(map);
    step(1, 0, 0);
    for (int i = 0; i < rounds; i++) step(0, 1, 0);
  endtask

  task automatic test_reset();
    reset_n = 0;
    model_reset();
    #1;
    n_vec++;
    if (round !== 0 || points !== 0 || best_points !== 0 || new_record !== 0 || done !== 0 || busy !== 0) begin
      n_err++;
      $display("FAIL reset_state: got r=%0d p=%0d b=%0d nr=%b d=%b busy=%b want all 0",
               round, points, best_points, new_record, done, busy);
    end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1;
    step(0, 1, 1);  // ignored in IDLE
  endtask

  task automatic test_first_game();
    run_game(2, 1, 5);
    step(0, 0, 1);
    n_vec++;
    if (round !== 4'd5 || points !== 8'd15 || done !== 1'b1 || new_record !== HS) begin
      n_err++;
      $display("FAIL first_commit: got r=%0d p=%0d d=%b nr=%b want r=5 p=15 d=1 nr=%b",
               round, points, done, new_record, HS);
    end
    step(0, 0, 0);
    n_vec++;
    if (best_points !== (HS ? 8'd15 : 8'd0)) begin
      n_err++;
      $display("FAIL first_best: got %0d want %0d", best_points, HS ? 15 : 0);
    end
  endtask

  task automatic test_no_record();
    run_game(0, 1, 3);
    step(0, 0, 1);
    n_vec++;
    if (points !== 8'd3 || done !== 1'b1 || new_record !== 1'b0) begin
      n_err++;
      $display("FAIL lower_commit: got p=%0d d=%b nr=%b want p=3 d=1 nr=0", points, done, new_record);
    end
    step(0, 0, 0);
    n_vec++;
    if (best_points !== (HS ? 8'd15 : 8'd0)) begin
      n_err++;
      $display("FAIL lower_best: got %0d want %0d", best_points, HS ? 15 : 0);
    end
    run_game(1, 2, 0);
    step(0, 0, 1);
    n_vec++;
    if (new_record !== 1'b0 || done !== 1'b1 || best_points !== 8'd0) begin
      n_err++;
      $display("FAIL zero_game: got nr=%b d=%b b=%0d want nr=0 d=1 b=0", new_record, done, best_points);
    end
    step(0, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_game(3, 3, 70);
    n_vec++;
    if (round !== 4'd15 || points !== 8'd255) begin
      n_err++;
      $display("FAIL saturate: got r=%0d p=%0d want r=15 p=255", round, points);
    end
    step(0, 0, 1);
    step(0, 0, 0);
  endtask

  task automatic test_same_cycle();
    run_game(1, 0, 2);
    step(0, 1, 1);
    n_vec++;
    if (round !== 4'd3 || points !== 8'd6 || done !== 1'b1 || new_record !== HS) begin
      n_err++;
      $display("FAIL same_cycle: got r=%0d p=%0d d=%b nr=%b want r=3 p=6 d=1 nr=%b",
               round, points, done, new_record, HS);
    end
    step(0, 0, 0);
  endtask

  task automatic test_restart();
    run_game(1, 1, 4);
    step(1, 1, 1);  // game_start wins over the others
    n_vec++;
    if (round !== 4'd0 || points !== 8'd0 || done !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL restart: got r=%0d p=%0d d=%b busy=%b want r=0 p=0 d=0 busy=1",
               round, points, done, busy);
    end
    step(0, 0, 0);
    step(0, 0, 0);
    n_vec++;
    if (best_points !== (HS ? 8'd15 : 8'd0)) begin
      n_err++;
      $display("FAIL restart_best: got %0d want %0d", best_points, HS ? 15 : 0);
    end
    step(0, 0, 1);
    step(0, 0, 0);
  endtask

  task automatic test_reset_abort();
    run_game(3, 2, 5);
    step(0, 0, 1);  // now in COMMIT with a pending record on map 2
    reset_n = 0;
    model_reset();
    #1;
    n_vec++;
    if (round !== 0 || points !== 0 || best_points !== 0 || new_record !== 0 || done !== 0 || busy !== 0) begin
      n_err++;
      $display("FAIL abort_state: got r=%0d p=%0d b=%0d nr=%b d=%b busy=%b want all 0",
               round, points, best_points, new_record, done, busy);
    end
    @(negedge clock);
    reset_n = 1;
    for (int m = 0; m < 4; m++) begin
      run_game(0, m, 0);
      n_vec++;
      if (best_points !== 8'd0) begin
        n_err++;
        $display("FAIL abort_table%0d: got %0d want 0", m, best_points);
      end
      step(0, 0, 1);
      step(0, 0, 0);
    end
  endtask

  initial begin
    model_reset();
    @(negedge clock);
    test_reset();
    test_first_game();
    test_no_record();
    test_back_to_back();
    test_same_cycle();
    test_restart();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
